// File: rtl/automaton_row_writer.sv
// Elementary 1-D cellular-automaton renderer: one generation per frame-buffer row.
// Build option CA_WRAP_EN: toroidal row edges; when undefined, pixels beyond the row read as 0.
module automaton_row_writer #(
  parameter int unsigned WORD_W    = 20,
  parameter int unsigned ROW_WORDS = 64,
  parameter int unsigned ROWS      = 1024,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned SEED_POS  = 640
) (
  input  logic              clk108,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic [7:0]        rule,
  input  logic              seed_load,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_address,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic [15:0]       gen_count
);

  localparam int unsigned PixW  = WORD_W * ROW_WORDS;
  localparam int unsigned RowW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned WordW = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
  localparam logic [PixW-1:0] SeedRow = PixW'(1) << SEED_POS;

  typedef enum logic [1:0] {StIdle, StWrite, StAdvance} state_e;

  state_e            state_q, state_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [WordW-1:0]  word_q, word_d;
  logic [PixW-1:0]   cur_row_q, cur_row_d;
  logic [PixW-1:0]   nxt_row_q, nxt_row_d;
  logic [7:0]        rule_q, rule_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_address_q, wr_address_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic [15:0]       gen_count_q, gen_count_d;

  // ext_row[p+1] is pixel p; ext_row[0] and ext_row[PixW+1] are the out-of-row neighbours.
  logic [PixW+1:0]   ext_row;
  logic [WORD_W+1:0] win;
  logic [WORD_W-1:0] nxt_word;

`ifdef CA_WRAP_EN
  assign ext_row = {cur_row_q[0], cur_row_q, cur_row_q[PixW-1]};
`else
  assign ext_row = {1'b0, cur_row_q, 1'b0};
`endif

  always_comb begin
    win = ext_row[word_q*WORD_W +: WORD_W+2];
    nxt_word = '0;
    for (int i = 0; i < WORD_W; i++) begin
      nxt_word[i] = rule_q[{win[i], win[i+1], win[i+2]}];
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    word_d       = word_q;
    cur_row_d    = cur_row_q;
    nxt_row_d    = nxt_row_q;
    rule_d       = rule_q;
    wr_en_d      = 1'b0;
    wr_address_d = wr_address_q;
    wr_data_d    = wr_data_q;
    busy_d       = busy_q;
    gen_count_d  = gen_count_q;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          rule_d  = rule;
          row_d   = '0;
          word_d  = '0;
          busy_d  = 1'b1;
          state_d = StWrite;
        end else if (seed_load) begin
          cur_row_d   = SeedRow;
          gen_count_d = '0;
        end
      end
      StWrite: begin
        wr_en_d      = 1'b1;
        wr_address_d = ADDR_W'(row_q) * ADDR_W'(ROW_WORDS) + ADDR_W'(word_q);
        wr_data_d    = cur_row_q[word_q*WORD_W +: WORD_W];
        nxt_row_d[word_q*WORD_W +: WORD_W] = nxt_word;
        if (word_q == WordW'(ROW_WORDS - 1)) begin
          state_d = StAdvance;
        end else begin
          word_d = word_q + 1'b1;
        end
      end
      StAdvance: begin
        cur_row_d   = nxt_row_q;
        gen_count_d = gen_count_q + 16'd1;
        word_d      = '0;
        if (row_q == RowW'(ROWS - 1)) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = StWrite;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk108 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      row_q        <= '0;
      word_q       <= '0;
      cur_row_q    <= SeedRow;
      nxt_row_q    <= '0;
      rule_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_address_q <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      gen_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      word_q       <= word_d;
      cur_row_q    <= cur_row_d;
      nxt_row_q    <= nxt_row_d;
      rule_q       <= rule_d;
      wr_en_q      <= wr_en_d;
      wr_address_q <= wr_address_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      gen_count_q  <= gen_count_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_address = wr_address_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign gen_count  = gen_count_q;

endmodule

// File: tb/tb_automaton_row_writer.sv
// Bench for automaton_row_writer: reference CA model feeds a write scoreboard, plus spot tables.
module tb_automaton_row_writer;

  localparam int WW    = 20;
  localparam int RW    = 64;
  localparam int ROWS  = 16;
  localparam int PIX   = WW * RW;
  localparam int FRAME = ROWS * (RW + 1);
`ifdef CA_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic        clk108 = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [7:0]  rule = 8'd0;
  logic        seed_load = 1'b0;
  logic        wr_en, wr_en0, busy, busy0;
  logic [15:0] wr_address, wr_address0, gen_count, gen_count0;
  logic [19:0] wr_data, wr_data0;

  automaton_row_writer #(.ROWS(ROWS), .SEED_POS(640)) dut (
    .clk108(clk108), .reset_n(reset_n), .frame_start(frame_start), .rule(rule),
    .seed_load(seed_load), .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data),
    .busy(busy), .gen_count(gen_count)
  );

  automaton_row_writer #(.ROWS(ROWS), .SEED_POS(0)) dut0 (
    .clk108(clk108), .reset_n(reset_n), .frame_start(frame_start), .rule(rule),
    .seed_load(seed_load), .wr_en(wr_en0), .wr_address(wr_address0), .wr_data(wr_data0),
    .busy(busy0), .gen_count(gen_count0)
  );

  always #5 clk108 = ~clk108;

  typedef struct {logic [15:0] addr; logic [19:0] data;} exp_t;
  typedef struct {int run; bit inst0; int addr; logic [19:0] data;} spot_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          vectors = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          exp_gen = 0;
  logic [PIX-1:0] mrow;
  logic [19:0] mem  [0:ROWS*RW-1];
  logic [19:0] mem0 [0:ROWS*RW-1];
  spot_t       spots [15];

  function automatic logic [PIX-1:0] next_gen(input logic [PIX-1:0] c, input logic [7:0] r);
    logic [PIX-1:0] n;
    logic l, rr;
    for (int p = 0; p < PIX; p++) begin
      if (p == 0) l = WRAP ? c[PIX-1] : 1'b0;
      else        l = c[p-1];
      if (p == PIX - 1) rr = WRAP ? c[0] : 1'b0;
      else              rr = c[p+1];
      n[p] = r[{l, c[p], rr}];
    end
    return n;
  endfunction

  function automatic logic [PIX-1:0] seed_row();
    logic [PIX-1:0] s;
    s = '0;
    s[640] = 1'b1;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every DUT write is popped and compared against the model's queue.
  always @(negedge clk108) begin
    if (wr_en === 1'b1) begin
      wr_cnt++;
      mem[wr_address[9:0]] <= wr_data;
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected write: addr %0d data %h, no write expected", wr_address, wr_data);
      end else begin
        e = exp_q.pop_front();
        if (e.addr !== wr_address || e.data !== wr_data) begin
          errors++;
          $display("FAIL write: addr %0d data %h, expected addr %0d data %h",
                   wr_address, wr_data, e.addr, e.data);
        end
      end
    end
    if (wr_en0 === 1'b1) mem0[wr_address0[9:0]] <= wr_data0;
  end

  task automatic push_frame(input logic [7:0] r);
    for (int row = 0; row < ROWS; row++) begin
      for (int w = 0; w < RW; w++) exp_q.push_back('{addr: 16'(row * RW + w), data: mrow[w*WW +: WW]});
      mrow = next_gen(mrow, r);
    end
  endtask

  // Runs one frame; at busy cycle `glitch` a second start, a seed_load and a new rule are offered.
  task automatic run_frame(input logic [7:0] r, input int glitch);
    int n;
    push_frame(r);
    wr_cnt = 0;
    @(negedge clk108);
    rule = r;
    frame_start = 1'b1;
    @(negedge clk108);
    frame_start = 1'b0;
    check("busy after start", {31'd0, busy}, 32'd1);
    check("no write in first cycle", {31'd0, wr_en}, 32'd0);
    n = 0;
    while (busy === 1'b1 && n < FRAME + 200) begin
      n++;
      if (n == glitch) begin
        frame_start = 1'b1;
        seed_load = 1'b1;
        rule = ~r;
      end else if (n == glitch + 1) begin
        frame_start = 1'b0;
        seed_load = 1'b0;
      end
      @(negedge clk108);
    end
    exp_gen += ROWS;
    check("busy cycles", n, FRAME);
    check("write count", wr_cnt, ROWS * RW);
    check("gen_count after frame", {16'd0, gen_count}, 32'(exp_gen));
    check("scoreboard drained", exp_q.size(), 0);
  endtask

  task automatic do_seed_load();
    @(negedge clk108);
    seed_load = 1'b1;
    @(negedge clk108);
    seed_load = 1'b0;
    mrow = seed_row();
    exp_gen = 0;
    check("gen_count after seed_load", {16'd0, gen_count}, 32'd0);
  endtask

  task automatic spot_check(input int run);
    for (int i = 0; i < 15; i++) begin
      if (spots[i].run == run) begin
        if (spots[i].inst0) check($sformatf("seed0 addr %0d", spots[i].addr),
                                  {12'd0, mem0[spots[i].addr]}, {12'd0, spots[i].data});
        else check($sformatf("addr %0d", spots[i].addr),
                   {12'd0, mem[spots[i].addr]}, {12'd0, spots[i].data});
      end
    end
  endtask

  initial begin
    int n;
    logic [19:0] wrap_word;
    wrap_word = WRAP ? 20'h80000 : 20'h00000;
    spots = '{
      '{1, 1'b0, 32,   20'h00001}, '{1, 1'b0, 95,   20'h80000}, '{1, 1'b0, 96, 20'h00002},
      '{1, 1'b0, 0,    20'h00000}, '{1, 1'b0, 31,   20'h00000}, '{1, 1'b0, 64, 20'h00000},
      '{1, 1'b0, 97,   20'h00000}, '{1, 1'b1, 0,    20'h00001}, '{1, 1'b1, 64, 20'h00002},
      '{1, 1'b1, 127,  wrap_word}, '{1, 1'b1, 65,   20'h00000},
      '{2, 1'b0, 32,   20'h00001}, '{2, 1'b0, 64,   20'hFFFFF}, '{2, 1'b0, 127, 20'hFFFFF},
      '{2, 1'b0, 1000, 20'hFFFFF}
    };
    mrow = seed_row();

    #12;
    check("reset wr_en", {31'd0, wr_en}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset wr_address", {16'd0, wr_address}, 32'd0);
    check("reset wr_data", {12'd0, wr_data}, 32'd0);
    check("reset gen_count", {16'd0, gen_count}, 32'd0);
    @(negedge clk108);
    reset_n = 1'b1;

    run_frame(8'd90, -1);
    spot_check(1);
    // Continuous frames; the in-frame start/seed_load/rule change must be ignored.
    run_frame(8'd90, 100);
    do_seed_load();
    run_frame(8'd0, -1);
    do_seed_load();
    run_frame(8'd255, 100);
    spot_check(2);

    // Asynchronous reset mid-frame at row 5, word 10.
    do_seed_load();
    push_frame(8'd90);
    @(negedge clk108);
    rule = 8'd90;
    frame_start = 1'b1;
    @(negedge clk108);
    frame_start = 1'b0;
    n = 0;
    while (!(wr_en === 1'b1 && wr_address == 16'(5 * RW + 10)) && n < 2 * FRAME) begin
      n++;
      @(negedge clk108);
    end
    check("reached row 5 word 10", {31'd0, n < 2 * FRAME}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async reset wr_en", {31'd0, wr_en}, 32'd0);
    check("async reset busy", {31'd0, busy}, 32'd0);
    check("async reset gen_count", {16'd0, gen_count}, 32'd0);
    exp_q.delete();
    mrow = seed_row();
    exp_gen = 0;
    @(negedge clk108);
    reset_n = 1'b1;
    run_frame(8'd90, -1);
    spot_check(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
